// File: rtl/vga_term_ctrl_pkg.sv
// Shared definitions for the VGA text-terminal write sequencer:
// character codes, FSM encoding and default geometry.
package vga_term_ctrl_pkg;

    localparam int H_DISP   = 1280;
    localparam int V_DISP   = 1024;
    localparam int DEF_COLS = H_DISP / 8;
    localparam int DEF_ROWS = V_DISP / 8;
    localparam int DEF_AW   = $clog2(DEF_COLS * DEF_ROWS);

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        ST_CLR_SCREEN = 2'd0,
        ST_IDLE       = 2'd1,
        ST_CLR_LINE   = 2'd2
    } term_state_t;

    function automatic logic is_printable(input logic [7:0] ch);
        return (ch >= CH_SPACE) && (ch <= CH_TILDE);
    endfunction

endpackage

// File: rtl/vga_term_ctrl_if.sv
// Byte-stream input handshake plus the character-memory write port.
interface vga_term_ctrl_if #(
    parameter int ADDR_WIDTH = 15
);
    logic                  char_valid;
    logic [7:0]            char_data;
    logic                  char_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_data;

    modport master (
        output char_valid, char_data,
        input  char_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  char_valid, char_data,
        output char_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/vga_term_ctrl_cursor.sv
// Cursor position with a running line-base address so the write
// address is line_base + col without a multiplier.
module vga_term_ctrl_cursor #(
    parameter  int COLS       = 160,
    parameter  int ROWS       = 128,
    parameter  int ADDR_WIDTH = 15,
    localparam int COL_W      = $clog2(COLS),
    localparam int ROW_W      = $clog2(ROWS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  newline,
    input  logic                  cr,
    input  logic                  bs,
    input  logic                  home,
    output logic [COL_W-1:0]      col,
    output logic [ROW_W-1:0]      row,
    output logic [ADDR_WIDTH-1:0] line_base,
    output logic                  at_last_col,
    output logic                  at_col0
);

    localparam logic [COL_W-1:0]      LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]      LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(COLS);

    assign at_last_col = (col == LAST_COL);
    assign at_col0     = (col == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            line_base <= '0;
        end else if (home) begin
            col       <= '0;
            row       <= '0;
            line_base <= '0;
        end else if (newline) begin
            col <= '0;
            // Bottom row wraps to the top; there is no scrolling.
            if (row == LAST_ROW) begin
                row       <= '0;
                line_base <= '0;
            end else begin
                row       <= row + 1'b1;
                line_base <= line_base + STRIDE;
            end
        end else if (cr) begin
            col <= '0;
        end else if (bs) begin
            if (!at_col0)
                col <= col - 1'b1;
        end else if (inc) begin
            col <= col + 1'b1;
        end
    end

endmodule

// File: rtl/vga_term_ctrl.sv
// Terminal-style write sequencer: turns a byte stream into writes
// to the text-mode character memory, with screen and line clears.
module vga_term_ctrl
    import vga_term_ctrl_pkg::*;
#(
    parameter  int COLS       = DEF_COLS,
    parameter  int ROWS       = DEF_ROWS,
    parameter  int ADDR_WIDTH = DEF_AW,
    localparam int COL_W      = $clog2(COLS),
    localparam int ROW_W      = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    vga_term_ctrl_if.slave   bus,
    output logic [COL_W-1:0] cur_col,
    output logic [ROW_W-1:0] cur_row,
    output logic             busy
);

    localparam logic [ADDR_WIDTH-1:0] SCREEN_LAST = ADDR_WIDTH'(COLS * ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_LAST   = ADDR_WIDTH'(COLS - 1);

    term_state_t           state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  wr_en, wr_en_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_nxt;
    logic [7:0]            wr_data, wr_data_nxt;

    logic                  c_inc, c_newline, c_cr, c_bs, c_home;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  at_last_col, at_col0;
    logic [7:0]            ch;

    vga_term_ctrl_cursor #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cursor (
        .clk         (clk),
        .reset       (reset),
        .inc         (c_inc),
        .newline     (c_newline),
        .cr          (c_cr),
        .bs          (c_bs),
        .home        (c_home),
        .col         (cur_col),
        .row         (cur_row),
        .line_base   (line_base),
        .at_last_col (at_last_col),
        .at_col0     (at_col0)
    );

    assign ch             = bus.char_data;
    assign cur_addr       = line_base + ADDR_WIDTH'(cur_col);
    assign bus.char_ready = (state == ST_IDLE);
    assign busy           = (state != ST_IDLE);
    assign bus.wr_en      = wr_en;
    assign bus.wr_addr    = wr_addr;
    assign bus.wr_data    = wr_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_CLR_SCREEN;
            cnt     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            wr_en   <= wr_en_nxt;
            wr_addr <= wr_addr_nxt;
            wr_data <= wr_data_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        c_inc       = 1'b0;
        c_newline   = 1'b0;
        c_cr        = 1'b0;
        c_bs        = 1'b0;
        c_home      = 1'b0;

        unique case (state)
            ST_CLR_SCREEN: begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = cnt;
                wr_data_nxt = CH_SPACE;
                if (cnt == SCREEN_LAST) begin
                    cnt_nxt   = '0;
                    c_home    = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            // Cursor already points at the new row; blank it from col 0.
            ST_CLR_LINE: begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = line_base + cnt;
                wr_data_nxt = CH_SPACE;
                if (cnt == LINE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_IDLE: begin
                if (bus.char_valid) begin
                    unique case (1'b1)
                        is_printable(ch): begin
                            wr_en_nxt   = 1'b1;
                            wr_addr_nxt = cur_addr;
                            wr_data_nxt = ch;
                            if (at_last_col) begin
                                c_newline = 1'b1;
                                state_nxt = ST_CLR_LINE;
                            end else begin
                                c_inc = 1'b1;
                            end
                        end
                        (ch == CH_LF): begin
                            c_newline = 1'b1;
                            state_nxt = ST_CLR_LINE;
                        end
                        (ch == CH_CR): begin
                            c_cr = 1'b1;
                        end
                        (ch == CH_BS): begin
                            if (!at_col0) begin
                                c_bs        = 1'b1;
                                wr_en_nxt   = 1'b1;
                                wr_addr_nxt = cur_addr - 1'b1;
                                wr_data_nxt = CH_SPACE;
                            end
                        end
                        (ch == CH_FF): begin
                            cnt_nxt   = '0;
                            state_nxt = ST_CLR_SCREEN;
                        end
                        default: ;
                    endcase
                end
            end

            default: state_nxt = ST_CLR_SCREEN;
        endcase
    end

endmodule

// File: tb/tb_vga_term_ctrl.sv
// Directed bench for vga_term_ctrl on a 4x3 screen.
module tb_vga_term_ctrl;

    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int AW   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cur_col;
    logic [1:0] cur_row;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int log_a[$];
    int log_d[$];
    int log_c[$];

    vga_term_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    vga_term_ctrl #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk     (clk),
        .reset   (rst),
        .bus     (bus),
        .cur_col (cur_col),
        .cur_row (cur_row),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            log_a.push_back(int'(bus.wr_addr));
            log_d.push_back(int'(bus.wr_data));
            log_c.push_back(cyc);
        end
    end

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
        log_c.delete();
    endtask

    task automatic push(input logic [7:0] b);
        bus.char_valid = 1'b1;
        bus.char_data  = b;
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.char_ready === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: char_ready never rose within 100 cycles", name);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic check_clear(input string name, input int base, input int n);
        checks++;
        if (log_a.size() !== n) begin
            failures++;
            $display("FAIL %s count: got %0d want %0d", name, log_a.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (log_a[i] !== base + i || log_d[i] !== 32'h20 ||
                    log_c[i] !== log_c[0] + i) begin
                    failures++;
                    $display("FAIL %s[%0d]: got a=%0d d=%0h c=+%0d want a=%0d d=20 c=+%0d",
                             name, i, log_a[i], log_d[i], log_c[i] - log_c[0], base + i, i);
                end
            end
        end
    endtask

    task automatic home_screen();
        push(8'h0C);
        wait_idle("ff_home");
        clear_log();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_addr !== 4'd0 || bus.wr_data !== 8'd0 ||
            bus.char_ready !== 1'b0 || busy !== 1'b1 ||
            cur_col !== 2'd0 || cur_row !== 2'd0) begin
            failures++;
            $display("FAIL reset_vals: got en=%b a=%0d d=%0h rdy=%b busy=%b col=%0d row=%0d want 0 0 0 0 1 0 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.char_ready, busy, cur_col, cur_row);
        end
        @(posedge clk);
        #1;
        clear_log();
        rst = 1'b0;
        wait_idle("reset_clear");
        check_clear("reset_clear", 0, 12);
        checks++;
        if (bus.char_ready !== 1'b1 || cur_col !== 2'd0 || cur_row !== 2'd0) begin
            failures++;
            $display("FAIL reset_after: got rdy=%b col=%0d row=%0d want 1 0 0",
                     bus.char_ready, cur_col, cur_row);
        end
        clear_log();
    endtask

    task automatic test_back_to_back();
        push(8'h41);
        push(8'h42);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (log_a.size() !== 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d want 2", log_a.size());
        end else begin
            checks++;
            if (log_a[0] !== 0 || log_d[0] !== 32'h41 || log_a[1] !== 1 ||
                log_d[1] !== 32'h42 || log_c[1] !== log_c[0] + 1) begin
                failures++;
                $display("FAIL b2b_writes: got (%0d,%0h)(%0d,%0h) gap=%0d want (0,41)(1,42) gap=1",
                         log_a[0], log_d[0], log_a[1], log_d[1], log_c[1] - log_c[0]);
            end
        end
        checks++;
        if (cur_col !== 2'd2 || cur_row !== 2'd0) begin
            failures++;
            $display("FAIL b2b_cursor: got col=%0d row=%0d want 2 0", cur_col, cur_row);
        end
        home_screen();
    endtask

    task automatic test_wrap_line();
        int not_ready = 0;
        push(8'h41);
        push(8'h42);
        push(8'h43);
        push(8'h44);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.char_ready !== 1'b1) not_ready++;
        end
        checks++;
        if (not_ready !== 4) begin
            failures++;
            $display("FAIL wrap_stall: got %0d not-ready cycles want 4", not_ready);
        end
        checks++;
        if (log_a.size() !== 8) begin
            failures++;
            $display("FAIL wrap_count: got %0d want 8", log_a.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (log_a[i] !== i || log_d[i] !== ((i < 4) ? 32'h41 + i : 32'h20) ||
                    log_c[i] !== log_c[0] + i) begin
                    failures++;
                    $display("FAIL wrap_write[%0d]: got a=%0d d=%0h want a=%0d d=%0h",
                             i, log_a[i], log_d[i], i, (i < 4) ? 32'h41 + i : 32'h20);
                end
            end
        end
        checks++;
        if (cur_col !== 2'd0 || cur_row !== 2'd1) begin
            failures++;
            $display("FAIL wrap_cursor: got col=%0d row=%0d want 0 1", cur_col, cur_row);
        end
        clear_log();
    endtask

    task automatic test_lf();
        bit hit9 = 0;
        push(8'h45);
        push(8'h46);
        push(8'h47);
        push(8'h48);
        wait_idle("lf_fill");
        push(8'h49);
        @(negedge clk);
        checks++;
        if (cur_col !== 2'd1 || cur_row !== 2'd2) begin
            failures++;
            $display("FAIL lf_pre: got col=%0d row=%0d want 1 2", cur_col, cur_row);
        end
        #1;
        clear_log();
        push(8'h0A);
        wait_idle("lf_clear");
        checks++;
        if (cur_col !== 2'd0 || cur_row !== 2'd0) begin
            failures++;
            $display("FAIL lf_cursor: got col=%0d row=%0d want 0 0", cur_col, cur_row);
        end
        check_clear("lf_clear", 0, 4);
        foreach (log_a[i]) if (log_a[i] == 9) hit9 = 1;
        checks++;
        if (hit9) begin
            failures++;
            $display("FAIL lf_no_char: got write at addr 9 want none");
        end
        clear_log();
    endtask

    task automatic test_bs_cr();
        home_screen();
        push(8'h41);
        push(8'h42);
        @(negedge clk);
        #1;
        clear_log();
        push(8'h08);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (log_a.size() !== 1 || log_a[0] !== 1 || log_d[0] !== 32'h20 || cur_col !== 2'd1) begin
            failures++;
            $display("FAIL bs_col2: got n=%0d col=%0d want n=1 (1,20) col=1",
                     log_a.size(), cur_col);
        end
        push(8'h08);
        @(negedge clk);
        #1;
        clear_log();
        push(8'h08);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (log_a.size() !== 0 || cur_col !== 2'd0 || cur_row !== 2'd0) begin
            failures++;
            $display("FAIL bs_col0: got n=%0d col=%0d row=%0d want 0 0 0",
                     log_a.size(), cur_col, cur_row);
        end
        push(8'h58);
        push(8'h59);
        push(8'h5A);
        push(8'h01);
        @(negedge clk);
        checks++;
        if (cur_col !== 2'd3 || cur_row !== 2'd0) begin
            failures++;
            $display("FAIL ignored_byte: got col=%0d row=%0d want 3 0", cur_col, cur_row);
        end
        #1;
        clear_log();
        push(8'h0D);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (log_a.size() !== 0 || cur_col !== 2'd0 || cur_row !== 2'd0 ||
            bus.char_ready !== 1'b1) begin
            failures++;
            $display("FAIL cr: got n=%0d col=%0d row=%0d rdy=%b want 0 0 0 1",
                     log_a.size(), cur_col, cur_row, bus.char_ready);
        end
        #1;
    endtask

    task automatic test_reset_mid();
        home_screen();
        push(8'h41);
        push(8'h42);
        push(8'h43);
        push(8'h44);
        @(posedge clk);
        #2;
        checks++;
        if (bus.wr_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre: got en=%b busy=%b want 1 1", bus.wr_en, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_addr !== 4'd0 || cur_row !== 2'd0 ||
            bus.char_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_async: got en=%b a=%0d row=%0d rdy=%b want 0 0 0 0",
                     bus.wr_en, bus.wr_addr, cur_row, bus.char_ready);
        end
        @(posedge clk);
        #1;
        clear_log();
        rst = 1'b0;
        wait_idle("mid_restart");
        check_clear("mid_restart", 0, 12);
    endtask

    initial begin
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;
        test_reset();
        test_back_to_back();
        test_wrap_line();
        test_lf();
        test_bs_cr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
